perip_bus_arbiter: RTL and testbench
====================================

# perip_bus_arbiter

Shares the single embedded peripheral bus (`mem_we` / `mem_addr` / bidirectional `mem_data`, as consumed by gpio and sibling perips) between NUM_REQ bus masters, e.g. the core load/store port and a DMA engine. Each master issues one word access at a time over a req/ack handshake. The block arbitrates round-robin, sequences one bus access per grant, drives write data onto the tri-state data bus, and captures read data.

## Interface
- NUM_REQ, 2: number of masters, ≥2.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-master access request; level, held until ack.
- we  in  NUM_REQ  per-master write enable; 1 = write, 0 = read.
- addr  in  NUM_REQ*ADDR_W  per-master address, packed, master i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  per-master write data, packed likewise.
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid only in the ack cycle of a read.
- bus_we  out  1  peripheral bus write strobe (to perips `mem_we`).
- bus_addr  out  ADDR_W  peripheral bus address (to perips `mem_addr`).
- bus_data  inout  DATA_W  peripheral bus data (to perips `mem_data`).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `req` bit is set, pick the winner by round-robin and latch its index, `we`, `addr` and `wdata`. Go to ACCESS. Otherwise stay in IDLE.
- Round-robin: search starts at (last_gnt+1) mod NUM_REQ. `last_gnt` updates to the winner on entry to ACCESS. Reset value is NUM_REQ-1, so master 0 wins first.
- ACCESS (exactly 1 cycle): `bus_addr` = latched address and `bus_we` = latched `we`.
  - Write: drive `bus_data` = latched wdata.
  - Read: `bus_data` = Z. Capture `bus_data` into the rdata register at the end of the cycle.
  - Always go to RESP.
- RESP (1 cycle): `ack[owner]`=1 and `rdata` is valid for a read. `bus_we`=0 and `bus_data`=Z. Go to IDLE.
- Masters must hold `req`/`we`/`addr`/`wdata` stable until they see ack, and must drop `req` in the cycle after ack, or keep it high to request again.
- Requests are never re-sampled in RESP, so a stale `req` from the owner during its ack cycle is ignored.
- Outside ACCESS: `bus_we`=0, `bus_addr`=0, `bus_data`=Z. The arbiter drives `bus_data` only during a write ACCESS, and the perips drive it only while `bus_we`=0. This prevents bus contention.
- `rdata` holds its last value outside RESP. For writes its content is unspecified.

## Timing
- Request seen in IDLE at cycle t: ACCESS at t+1, ack at t+2. Next IDLE decision at t+3.
- Throughput: one access per 3 cycles. Fairness bound: a waiting master gets its grant within NUM_REQ grants.
- Simultaneous requests: the winner follows the round-robin pointer, and losers wait in IDLE.
- A request arriving during ACCESS/RESP is served at the next IDLE.
- Reset values: state=IDLE, `ack`=0, `rdata`=0, `bus_we`=0, `bus_addr`=0, `bus_data`=Z, last_gnt=NUM_REQ-1.
- Reset asserted in ACCESS or RESP aborts the access: no ack is issued, and the write strobe drops next cycle. The master must reissue its request after reset.
- `ack` and `rdata` are registered outputs. `bus_we` and `bus_addr` are registered or decoded from registered state only; no combinational path from `req`.

## Structure
- Package `perip_bus_pkg`: the state enum (IDLE/ACCESS/RESP), ADDR_W/DATA_W defaults, and the perips base mask constant 32'hffff0000, shared with the perips.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req` and `last_gnt`. Outputs a one-hot grant and a valid bit. It is reused by future multi-master blocks.
- Top level: FSM, latch registers, tri-state driver.

## Test plan
- Single write: master 0 writes 0x000000A5 to 0xffff0000. Required response: in ACCESS, `bus_we`=1 and `bus_addr`=0xffff0000 for exactly one cycle, and `bus_data`=0xA5. `ack[0]` pulses at t+2, and the gpio data register reads 0xA5 afterwards.
- Read: master 1 reads 0xffff0004 with the peripheral returning 0x0000000F. Required response: `ack[1]` at t+2 with `rdata`=0x0000000F. `bus_data` is Z from the arbiter throughout.
- Contention: both masters request continuously from reset. Required response: grants alternate 0,1,0,1; acks are 3 cycles apart; never both bits of `ack` set.
- Stale request: master 0 keeps `req` high through its ack cycle while master 1 is idle. Required response: exactly one new access is started, at the next IDLE, with no double access in the ack cycle.
- Reset in the write ACCESS cycle. Required response: no ack is issued, and `bus_we`=0 and `bus_data`=Z on the next cycle. The state is IDLE, and the first grant after reset goes to master 0.
- Bus-contention check: an assertion that the arbiter drives `bus_data` only when `bus_we`=1, over a random mix of 1000 reads and writes.

Source files
------------

// File: rtl/perip_bus_pkg.sv
// perip_bus_pkg: shared types and constants for the peripheral bus and its arbiter
package perip_bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] PERIPS_BASE_MASK = 32'hffff0000;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last grant
module rr_arbiter #(
  parameter int N = 2,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last_gnt,
  output logic [N-1:0]  gnt,
  output logic          valid
);
  always_comb begin
    gnt = '0;
    for (int k = N; k >= 1; k--)
      if (req[LW'((int'(last_gnt) + k) % N)]) begin
        gnt = '0;
        gnt[LW'((int'(last_gnt) + k) % N)] = 1'b1;
      end
    valid = |req;
  end
endmodule

// File: rtl/perip_bus_arbiter.sv
// perip_bus_arbiter: round-robin sharing of the peripheral bus, one word access per grant
module perip_bus_arbiter
  import perip_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      bus_we,
  output logic [ADDR_W-1:0]         bus_addr,
  inout  wire  [DATA_W-1:0]         bus_data
);
  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  state_t r_state, w_next;
  logic [LW-1:0] r_last, r_owner, w_idx;
  logic [NUM_REQ-1:0] w_gnt, r_ack;
  logic w_valid, r_we, w_drive;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;

  rr_arbiter #(.N(NUM_REQ), .LW(LW)) u_rr (
    .req(req), .last_gnt(r_last), .gnt(w_gnt), .valid(w_valid)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_gnt[i]) w_idx = LW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= LW'(NUM_REQ - 1);
      r_owner <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= '0;
      if (r_state == IDLE && w_valid) begin
        r_owner <= w_idx;
        r_last  <= w_idx;
        r_we    <= we[w_idx];
        r_addr  <= addr[w_idx*ADDR_W +: ADDR_W];
        r_wdata <= wdata[w_idx*DATA_W +: DATA_W];
      end
      if (r_state == ACCESS) begin
        r_ack[r_owner] <= 1'b1;
        if (!r_we) r_rdata <= bus_data;
      end
    end
  end

  // requests are only looked at in IDLE, so a held req during RESP is ignored
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = w_valid ? ACCESS : IDLE;
    else if (r_state == ACCESS) w_next = RESP;
  end

  always_comb begin
    w_drive  = (r_state == ACCESS) && r_we;
    bus_we   = w_drive;
    bus_addr = (r_state == ACCESS) ? r_addr : '0;
  end

  assign bus_data = w_drive ? r_wdata : 'z;
  assign ack = r_ack;
  assign rdata = r_rdata;
endmodule

// File: tb/tb_perip_bus_arbiter.sv
// tb_perip_bus_arbiter: directed checks of the bus arbiter with a gpio-like peripheral model
module tb_perip_bus_arbiter;
  import perip_bus_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req = '0, we = '0;
  logic [63:0] addr = '0, wdata = '0;
  logic [1:0] ack;
  logic [31:0] rdata, bus_addr, p_val;
  logic bus_we;
  wire [31:0] bus_data;
  logic [31:0] gpio_reg = '0;
  int n_cmp = 0, n_err = 0;

  perip_bus_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .bus_we(bus_we), .bus_addr(bus_addr), .bus_data(bus_data)
  );

  always #5 clk = ~clk;

  always_comb
    p_val = ((bus_addr & PERIPS_BASE_MASK) != PERIPS_BASE_MASK) ? 32'h0 :
            (bus_addr == 32'hffff0004) ? 32'h0000000F : gpio_reg;
  assign bus_data = bus_we ? 'z : p_val;
  always @(posedge clk) if (bus_we && bus_addr == 32'hffff0000) gpio_reg <= bus_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp += 4;
    if (ack !== 2'b00) begin n_err++; $display("FAIL reset_ack got %h want 0", ack); end
    if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
    if (bus_we !== 1'b0) begin n_err++; $display("FAIL reset_bus_we got %b want 0", bus_we); end
    if (bus_addr !== 32'h0) begin n_err++; $display("FAIL reset_bus_addr got %h want 0", bus_addr); end
  endtask

  task automatic test_write();
    req = 2'b01; we = 2'b01; addr[31:0] = 32'hffff0000; wdata[31:0] = 32'h000000A5;
    tick();
    n_cmp += 4;
    if (bus_we !== 1'b1) begin n_err++; $display("FAIL wr_bus_we got %b want 1", bus_we); end
    if (bus_addr !== 32'hffff0000) begin n_err++; $display("FAIL wr_bus_addr got %h want ffff0000", bus_addr); end
    if (bus_data !== 32'h000000A5) begin n_err++; $display("FAIL wr_bus_data got %h want a5", bus_data); end
    if (ack !== 2'b00) begin n_err++; $display("FAIL wr_ack_early got %b want 00", ack); end
    tick();
    n_cmp += 3;
    if (ack !== 2'b01) begin n_err++; $display("FAIL wr_ack got %b want 01", ack); end
    if (bus_we !== 1'b0) begin n_err++; $display("FAIL wr_resp_we got %b want 0", bus_we); end
    if (bus_addr !== 32'h0) begin n_err++; $display("FAIL wr_resp_addr got %h want 0", bus_addr); end
    req = '0; we = '0;
    tick();
    n_cmp += 2;
    if (ack !== 2'b00) begin n_err++; $display("FAIL wr_ack_drop got %b want 00", ack); end
    if (gpio_reg !== 32'h000000A5) begin n_err++; $display("FAIL wr_gpio got %h want a5", gpio_reg); end
  endtask

  task automatic test_read();
    req = 2'b10; we = 2'b00; addr[63:32] = 32'hffff0004;
    tick();
    n_cmp += 3;
    if (bus_we !== 1'b0) begin n_err++; $display("FAIL rd_bus_we got %b want 0", bus_we); end
    if (bus_addr !== 32'hffff0004) begin n_err++; $display("FAIL rd_bus_addr got %h want ffff0004", bus_addr); end
    if (bus_data !== 32'h0000000F) begin n_err++; $display("FAIL rd_bus_data got %h want f", bus_data); end
    tick();
    n_cmp += 2;
    if (ack !== 2'b10) begin n_err++; $display("FAIL rd_ack got %b want 10", ack); end
    if (rdata !== 32'h0000000F) begin n_err++; $display("FAIL rd_rdata got %h want f", rdata); end
    req = '0;
    tick();
  endtask

  task automatic test_contention();
    logic [31:0] ea;
    logic [31:0] ed;
    logic [1:0] eack;
    rst = 1'b1; tick(); rst = 1'b0;
    we = 2'b00; addr = {32'hffff0004, 32'hffff0000}; req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      ea = (g % 2 == 0) ? 32'hffff0000 : 32'hffff0004;
      ed = (g % 2 == 0) ? 32'h000000A5 : 32'h0000000F;
      eack = (g % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      n_cmp++;
      if (bus_addr !== ea) begin n_err++; $display("FAIL cont_addr[%0d] got %h want %h", g, bus_addr, ea); end
      tick();
      n_cmp += 2;
      if (ack !== eack) begin n_err++; $display("FAIL cont_ack[%0d] got %b want %b", g, ack, eack); end
      if (rdata !== ed) begin n_err++; $display("FAIL cont_rdata[%0d] got %h want %h", g, rdata, ed); end
      tick();
      n_cmp++;
      if (ack !== 2'b00) begin n_err++; $display("FAIL cont_gap[%0d] got %b want 00", g, ack); end
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_stale();
    req = 2'b01; we = 2'b00; addr[31:0] = 32'hffff0004;
    tick(); tick();
    n_cmp++;
    if (ack !== 2'b01) begin n_err++; $display("FAIL stale_ack1 got %b want 01", ack); end
    tick();
    n_cmp += 2;
    if (bus_addr !== 32'h0) begin n_err++; $display("FAIL stale_idle_addr got %h want 0", bus_addr); end
    if (ack !== 2'b00) begin n_err++; $display("FAIL stale_idle_ack got %b want 00", ack); end
    tick();
    n_cmp++;
    if (bus_addr !== 32'hffff0004) begin n_err++; $display("FAIL stale_access got %h want ffff0004", bus_addr); end
    tick();
    n_cmp++;
    if (ack !== 2'b01) begin n_err++; $display("FAIL stale_ack2 got %b want 01", ack); end
    req = '0;
    tick();
    n_cmp++;
    if (bus_addr !== 32'h0) begin n_err++; $display("FAIL stale_end got %h want 0", bus_addr); end
  endtask

  task automatic test_reset_in_access();
    req = 2'b01; we = 2'b01; addr[31:0] = 32'hffff0000; wdata[31:0] = 32'h0000005A;
    tick();
    n_cmp++;
    if (bus_we !== 1'b1) begin n_err++; $display("FAIL rst_acc_we got %b want 1", bus_we); end
    rst = 1'b1;
    tick();
    rst = 1'b0; req = '0; we = '0;
    n_cmp += 3;
    if (bus_we !== 1'b0) begin n_err++; $display("FAIL rst_acc_we_drop got %b want 0", bus_we); end
    if (ack !== 2'b00) begin n_err++; $display("FAIL rst_acc_ack got %b want 00", ack); end
    if (bus_addr !== 32'h0) begin n_err++; $display("FAIL rst_acc_addr got %h want 0", bus_addr); end
    tick();
    n_cmp++;
    if (ack !== 2'b00) begin n_err++; $display("FAIL rst_acc_noack got %b want 00", ack); end
    addr = {32'hffff0004, 32'hffff0000}; req = 2'b11;
    tick();
    n_cmp++;
    if (bus_addr !== 32'hffff0000) begin n_err++; $display("FAIL rst_first_grant got %h want ffff0000", bus_addr); end
    tick();
    n_cmp++;
    if (ack !== 2'b01) begin n_err++; $display("FAIL rst_first_ack got %b want 01", ack); end
    req = '0;
    tick();
  endtask

  task automatic test_random_mix();
    logic [31:0] exp_gpio, a, d, exp_rd;
    int m, w;
    exp_gpio = gpio_reg;
    for (int n = 0; n < 1000; n++) begin
      m = $urandom_range(0, 1);
      w = $urandom_range(0, 1);
      a = $urandom_range(0, 1) ? 32'hffff0004 : 32'hffff0000;
      d = $urandom;
      req = '0; we = '0;
      req[m] = 1'b1; we[m] = w[0];
      addr[m*32 +: 32] = a; wdata[m*32 +: 32] = d;
      exp_rd = (a == 32'hffff0004) ? 32'h0000000F : exp_gpio;
      tick();
      n_cmp++;
      if (w[0] && bus_data !== d) begin n_err++; $display("FAIL mix_wdata[%0d] got %h want %h", n, bus_data, d); end
      else if (!w[0] && bus_data !== p_val) begin n_err++; $display("FAIL mix_contention[%0d] got %h want %h", n, bus_data, p_val); end
      if (w[0] && a == 32'hffff0000) exp_gpio = d;
      tick();
      n_cmp += 2;
      if (ack !== (2'b01 << m)) begin n_err++; $display("FAIL mix_ack[%0d] got %b want %b", n, ack, 2'b01 << m); end
      if (bus_data !== p_val) begin n_err++; $display("FAIL mix_resp_drive[%0d] got %h want %h", n, bus_data, p_val); end
      if (!w[0]) begin
        n_cmp++;
        if (rdata !== exp_rd) begin n_err++; $display("FAIL mix_rdata[%0d] got %h want %h", n, rdata, exp_rd); end
      end
      req = '0;
      tick();
    end
    n_cmp++;
    if (gpio_reg !== exp_gpio) begin n_err++; $display("FAIL mix_gpio got %h want %h", gpio_reg, exp_gpio); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_stale();
    test_write();
    test_reset_in_access();
    test_random_mix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
